bdl_desc_bank: RTL and testbench
================================

# bdl_desc_bank

Multi-channel buffer-descriptor-list register bank for the DELQA controller; successor to the single fixed-size BDL register set. It holds one complete descriptor per channel (receive and transmit by default), loads it word-serially from the Q-bus DMA engine with an auto-incrementing pointer, and decodes the valid/chain bits of the address-descriptor word. It accepts status-word writeback from the MAC side and releases the slot with the flag word restored to 16'hFFFF.

## Interface
- CH, 2: number of independent descriptor channels (ch 0 = RX, ch 1 = TX); range 1–4.
- DW, 16: word width; DW ≥ 16.
- NUM, 6: words per descriptor (flag, addr-desc/hi, addr lo, length, status1, status2); range 6–8.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_start  in  1  begin loading into channel ld_ch.
- ld_ch  in  2  target channel for ld_start and ld_we.
- ld_we  in  1  load-word strobe, one word per asserted cycle.
- ld_data  in  DW  load word.
- ld_err  out  1  one-cycle pulse on an ignored ld_start or ld_we.
- st_we  in  1  status writeback strobe.
- st_ch  in  2  status target channel.
- st_sel  in  1  0 = word NUM-2 (status1), 1 = word NUM-1 (status2).
- st_data  in  DW  status word.
- rel  in  CH  per-channel release request.
- rd_ch  in  2  read channel.
- rd_addr  in  3  read word index.
- rd_data  out  DW  read data.
- desc_vld  out  CH  descriptor full and its V bit (word1[15]) is set.
- desc_chain  out  CH  word1[14] of a full descriptor with V set.
- busy  out  CH  channel in LOAD state.

## Operation
- Per-channel FSM: EMPTY → LOAD → FULL → EMPTY.
- EMPTY: ld_start with matching ld_ch enters LOAD and clears that channel's word pointer to 0.
- LOAD: each ld_we writes word[ptr] and increments ptr. The write at ptr = NUM-1 enters FULL. ld_start in LOAD restarts the load: pointer is set to 0; words already written are kept until overwritten.
- FULL: desc_vld = word1[15]; desc_chain = word1[15] & word1[14]. A full descriptor with V = 0 has desc_vld = 0 and still waits for rel.
- st_we writes the selected status word only while the channel is FULL; st_we in any other state is ignored silently.
- rel[c] in FULL or LOAD: word0 ← 16'hFFFF (upper bits above 16 also set), state → EMPTY. All other words are kept. rel in EMPTY has no effect.
- ld_err pulses for ld_start to a FULL channel, ld_we to a channel not in LOAD, or ld_ch/st_ch ≥ CH.
- Same-cycle events:
  - Load and status writes to different channels both take effect.
  - rel overrides ld_we, ld_start and st_we to the same channel; the word write is dropped and no ld_err is raised.
- rd_addr ≥ NUM or rd_ch ≥ CH reads 0.

## Timing
- Reset values:
  - Every channel EMPTY; word0 = all ones, other words 0.
  - desc_vld = 0, desc_chain = 0, busy = 0, ld_err = 0, rd_data = 0 (registered mode).
- Load: NUM ld_we cycles after ld_start. desc_vld is valid on the cycle after the final ld_we edge. ld_we may be asserted back-to-back and may have gaps.
- ld_we in the same cycle as ld_start is an error for an EMPTY channel (state still EMPTY). For a LOAD channel it is ignored and flagged; the restart wins.
- Status and release take effect at the next posedge; desc_vld falls the cycle after rel.
- Read latency: 0 cycles (combinational) by default. Write-then-read of the same word returns the new value on the cycle after the write edge.
- Reset asserted mid-load returns to reset values immediately, with no clock required.

## Configuration
- BDL_RDREG_EN defined: rd_data is registered, giving 1-cycle latency. rd_data reflects state as of the edge that samples rd_ch/rd_addr, which gives read-before-write on a same-edge write.
- BDL_RDREG_EN undefined: rd_data is a combinational mux.

## Test plan
- Reset, then read ch0/ch1 words 0..5 → 16'hFFFF, 0, 0, 0, 0, 0; desc_vld = 2'b00.
- ld_start ch1, then 6 ld_we with words 16'h8000, 16'hC012, 16'h3400, 16'hFA00, 0, 0 → busy[1] high for 6 cycles; desc_vld[1] = 1 and desc_chain[1] = 1 the cycle after the 6th write.
- Load ch0 with word1 = 16'h4000 → FULL with desc_vld[0] = 0. Then st_we sel0 16'h2000 and sel1 16'h0060 → words 4/5 read back 16'h2000/16'h0060.
- rel[0] → next cycle word0 = 16'hFFFF, word4 still 16'h2000, desc_vld[0] = 0. A further st_we to ch0 leaves word4 unchanged.
- ld_we to an EMPTY channel, ld_start to a FULL channel, ld_ch = 3 with CH = 2 → ld_err pulses once per event and no state changes.
- Load ch0 for 3 words, then pulse rst_n low with clk stopped → outputs at reset values; ld_start again followed by 6 writes → full load completes normally. Repeat with BDL_RDREG_EN and check the 1-cycle read latency.

Source files
------------

// File: rtl/bdl_desc_bank.sv
// Per-channel DELQA descriptor bank: word-serial load, status writeback, release. No backpressure; illegal strobes are dropped and flagged on ld_err.
// Read is combinational by default; define BDL_RDREG_EN for a registered 1-cycle read.
module bdl_desc_bank #(
    parameter int CH  = 2,
    parameter int DW  = 16,
    parameter int NUM = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic [1:0]    ld_ch,
    input  logic          ld_we,
    input  logic [DW-1:0] ld_data,
    output logic          ld_err,
    input  logic          st_we,
    input  logic [1:0]    st_ch,
    input  logic          st_sel,
    input  logic [DW-1:0] st_data,
    input  logic [CH-1:0] rel,
    input  logic [1:0]    rd_ch,
    input  logic [2:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [CH-1:0] desc_vld,
    output logic [CH-1:0] desc_chain,
    output logic [CH-1:0] busy
);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FULL} state_t;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [2:0]    ptr_q   [CH];
    logic [2:0]    ptr_d   [CH];
    logic [DW-1:0] mem_q   [CH][NUM];
    logic [CH-1:0] wr_en;
    logic [2:0]    wr_idx  [CH];
    logic [DW-1:0] wr_dat  [CH];
    logic          ld_err_q, ld_err_d;
    logic          ld_ch_ok, st_ch_ok;
    logic [DW-1:0] rd_mux;

    assign ld_ch_ok = int'(ld_ch) < CH;
    assign st_ch_ok = int'(st_ch) < CH;

    always_comb begin
        ld_err_d = ((ld_start || ld_we) && !ld_ch_ok) || (st_we && !st_ch_ok);
        for (int c = 0; c < CH; c++) begin
            logic ld_hit, st_hit;
            ld_hit     = ld_ch_ok && (int'(ld_ch) == c);
            st_hit     = st_ch_ok && (int'(st_ch) == c) && st_we;
            state_d[c] = state_q[c];
            ptr_d[c]   = ptr_q[c];
            wr_en[c]   = 1'b0;
            wr_idx[c]  = ptr_q[c];
            wr_dat[c]  = ld_data;
            // A release swallows every other same-channel event without flagging it.
            if (rel[c]) begin
                state_d[c] = S_EMPTY;
            end else begin
                case (state_q[c])
                    S_EMPTY: begin
                        if (ld_hit && ld_we) begin
                            ld_err_d = 1'b1;
                        end else if (ld_hit && ld_start) begin
                            state_d[c] = S_LOAD;
                            ptr_d[c]   = 3'd0;
                        end
                    end
                    S_LOAD: begin
                        if (ld_hit && ld_start) begin
                            ptr_d[c] = 3'd0;
                            if (ld_we) ld_err_d = 1'b1;
                        end else if (ld_hit && ld_we) begin
                            wr_en[c] = 1'b1;
                            ptr_d[c] = ptr_q[c] + 3'd1;
                            if (ptr_q[c] == 3'(NUM - 1)) state_d[c] = S_FULL;
                        end
                    end
                    S_FULL: begin
                        if (ld_hit && (ld_start || ld_we)) ld_err_d = 1'b1;
                        if (st_hit) begin
                            wr_en[c]  = 1'b1;
                            wr_idx[c] = 3'(NUM - 2) + {2'b00, st_sel};
                            wr_dat[c] = st_data;
                        end
                    end
                    default: state_d[c] = S_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_err_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= S_EMPTY;
                ptr_q[c]   <= 3'd0;
                for (int w = 0; w < NUM; w++) mem_q[c][w] <= (w == 0) ? '1 : '0;
            end
        end else begin
            ld_err_q <= ld_err_d;
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                ptr_q[c]   <= ptr_d[c];
                if (rel[c] && state_q[c] != S_EMPTY) begin
                    mem_q[c][0] <= '1;
                end else begin
                    for (int w = 0; w < NUM; w++) begin
                        if (wr_en[c] && wr_idx[c] == 3'(w)) mem_q[c][w] <= wr_dat[c];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CH; c++) begin
            busy[c]       = (state_q[c] == S_LOAD);
            desc_vld[c]   = (state_q[c] == S_FULL) && mem_q[c][1][15];
            desc_chain[c] = (state_q[c] == S_FULL) && mem_q[c][1][15] && mem_q[c][1][14];
            for (int w = 0; w < NUM; w++) begin
                if (rd_ch == 2'(c) && rd_addr == 3'(w)) rd_mux = mem_q[c][w];
            end
        end
    end

    assign ld_err = ld_err_q;

`ifdef BDL_RDREG_EN
    logic [DW-1:0] rd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_mux;
    end
    assign rd_data = rd_q;
`else
    assign rd_data = rd_mux;
`endif

endmodule

// File: tb/tb_bdl_desc_bank.sv
// Scoreboard bench for bdl_desc_bank; follows BDL_RDREG_EN for read latency.
module tb_bdl_desc_bank;
    localparam int CH = 2, DW = 16, NUM = 6;
`ifdef BDL_RDREG_EN
    localparam int RDLAT = 1;
`else
    localparam int RDLAT = 0;
`endif
    localparam int K_RD = 0, K_VLD = 1, K_CHN = 2, K_BSY = 3, K_ERR = 4;

    logic clk = 1'b0, clk_en = 1'b1, rst_n = 1'b0;
    logic ld_start = 0, ld_we = 0, st_we = 0, st_sel = 0, ld_err;
    logic [1:0] ld_ch = 0, st_ch = 0, rd_ch = 0;
    logic [2:0] rd_addr = 0;
    logic [DW-1:0] ld_data = 0, st_data = 0, rd_data;
    logic [CH-1:0] rel = 0, desc_vld, desc_chain, busy;

    bdl_desc_bank #(.CH(CH), .DW(DW), .NUM(NUM)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_ch(ld_ch), .ld_we(ld_we),
        .ld_data(ld_data), .ld_err(ld_err), .st_we(st_we), .st_ch(st_ch), .st_sel(st_sel),
        .st_data(st_data), .rel(rel), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .desc_vld(desc_vld), .desc_chain(desc_chain), .busy(busy)
    );

    always #5 if (clk_en) clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         sb_due[$], sb_kind[$], sb_ch[$];
    logic [15:0] sb_exp[$];
    string      sb_tag[$];
    logic [15:0] mw [CH][NUM];
    logic [15:0] ldw [NUM];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int kind, input int ch, input logic [15:0] exp,
                           input string tag, input int lat);
        sb_due.push_back(cyc + lat); sb_kind.push_back(kind); sb_ch.push_back(ch);
        sb_exp.push_back(exp); sb_tag.push_back(tag);
    endtask

    always @(negedge clk) begin : monitor
        int i;
        logic [15:0] obs;
        i = 0;
        while (i < sb_due.size()) begin
            if (sb_due[i] <= cyc) begin
                case (sb_kind[i])
                    K_RD:    obs = rd_data;
                    K_VLD:   obs = {15'd0, desc_vld[sb_ch[i]]};
                    K_CHN:   obs = {15'd0, desc_chain[sb_ch[i]]};
                    K_BSY:   obs = {15'd0, busy[sb_ch[i]]};
                    default: obs = {15'd0, ld_err};
                endcase
                chk(sb_tag[i], obs, sb_exp[i]);
                sb_due.delete(i); sb_kind.delete(i); sb_ch.delete(i);
                sb_exp.delete(i); sb_tag.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int w = 0; w < NUM; w++) mw[c][w] = (w == 0) ? 16'hFFFF : 16'h0000;
    endtask

    task automatic rd(input int c, input int w, input string tag);
        logic [15:0] e;
        tick();
        rd_ch = 2'(c); rd_addr = 3'(w);
        e = 16'h0;
        if (c < CH && w < NUM) e = mw[c][w];
        sb_push(K_RD, 0, e, tag, RDLAT);
    endtask

    task automatic flags(input int c, input logic v, input logic ch, input logic b, input string tag);
        sb_push(K_VLD, c, {15'd0, v}, {tag, "_vld"}, 0);
        sb_push(K_CHN, c, {15'd0, ch}, {tag, "_chain"}, 0);
        sb_push(K_BSY, c, {15'd0, b}, {tag, "_busy"}, 0);
    endtask

    // Loads ldw[] into channel c; optionally a status2 write to channel sc rides the first word.
    task automatic load(input int c, input bit st_on, input int sc, input string tag);
        tick();
        ld_start = 1; ld_ch = 2'(c);
        for (int i = 0; i < NUM; i++) begin
            tick();
            ld_start = 0; ld_we = 1; ld_data = ldw[i]; mw[c][i] = ldw[i];
            st_we = 0;
            if (st_on && i == 0) begin
                st_we = 1; st_ch = 2'(sc); st_sel = 1; st_data = 16'h5A5A;
                mw[sc][NUM-1] = 16'h5A5A;
            end
            sb_push(K_BSY, c, 16'd1, {tag, "_busy_ld"}, 0);
            sb_push(K_ERR, 0, 16'd0, {tag, "_err_ld"}, 0);
        end
        tick();
        ld_we = 0; st_we = 0;
        flags(c, ldw[1][15], ldw[1][15] & ldw[1][14], 1'b0, tag);
    endtask

    task automatic err_evt(input logic s, input logic w, input logic [1:0] lc,
                           input logic sw, input logic [1:0] sc, input string tag);
        tick();
        ld_start = s; ld_we = w; ld_ch = lc; st_we = sw; st_ch = sc; st_sel = 0; st_data = 16'hDEAD;
        tick();
        ld_start = 0; ld_we = 0; st_we = 0;
        sb_push(K_ERR, 0, 16'd1, tag, 0);
        tick();
        sb_push(K_ERR, 0, 16'd0, {tag, "_clr"}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, pending %0d", sb_due.size());
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", desc_vld, 2'b00);
        chk("rst_busy", busy, 2'b00);
        chk("rst_err", ld_err, 1'b0);
`ifdef BDL_RDREG_EN
        chk("rst_rd", rd_data, 16'h0);
`endif
        rst_n = 1;

        for (int c = 0; c < CH; c++)
            for (int w = 0; w < NUM; w++) rd(c, w, $sformatf("rst_rd_c%0d_w%0d", c, w));
        tick();
        flags(0, 0, 0, 0, "rst0"); flags(1, 0, 0, 0, "rst1");

        ldw = '{16'h8000, 16'hC012, 16'h3400, 16'hFA00, 16'h0000, 16'h0000};
        load(1, 0, 0, "ld1");

        ldw = '{16'h0000, 16'h4000, 16'h1234, 16'h0040, 16'h0000, 16'h0000};
        load(0, 0, 0, "ld0_novld");
        sb_push(K_VLD, 1, 16'd1, "ld0_ch1_vld", 0);
        tick(); st_we = 1; st_ch = 0; st_sel = 0; st_data = 16'h2000;
        tick(); st_sel = 1; st_data = 16'h0060;
        tick(); st_we = 0;
        mw[0][4] = 16'h2000; mw[0][5] = 16'h0060;
        rd(0, 4, "st1_rd"); rd(0, 5, "st2_rd");

        tick(); rel = 2'b01;
        tick(); rel = 2'b00;
        mw[0][0] = 16'hFFFF;
        flags(0, 0, 0, 0, "rel0");
        rd(0, 0, "rel0_w0"); rd(0, 4, "rel0_w4");
        tick(); st_we = 1; st_ch = 0; st_sel = 0; st_data = 16'h1111;
        tick(); st_we = 0;
        sb_push(K_ERR, 0, 16'd0, "st_empty_err", 0);
        rd(0, 4, "st_empty_w4");

        err_evt(0, 1, 2'd0, 0, 2'd0, "err_we_empty");
        err_evt(1, 0, 2'd1, 0, 2'd0, "err_start_full");
        flags(1, 1, 1, 0, "err_full_kept");
        err_evt(1, 0, 2'd3, 0, 2'd0, "err_ldch_oob");
        err_evt(0, 0, 2'd0, 1, 2'd2, "err_stch_oob");
        err_evt(1, 1, 2'd0, 0, 2'd0, "err_start_we_empty");
        flags(0, 0, 0, 0, "err_empty_kept");
        rd(1, 0, "err_w0_kept"); rd(0, 0, "err_ch0_w0");

        // Partial load, then a restart carrying an ignored ld_we.
        tick(); ld_start = 1; ld_ch = 0;
        tick(); ld_start = 0; ld_we = 1; ld_data = 16'hAAAA; mw[0][0] = 16'hAAAA;
        tick(); ld_data = 16'hBBBB; mw[0][1] = 16'hBBBB;
        tick(); ld_start = 1; ld_data = 16'hCCCC;
        tick(); ld_start = 0; ld_we = 0;
        sb_push(K_ERR, 0, 16'd1, "restart_err", 0);
        sb_push(K_BSY, 0, 16'd1, "restart_busy", 0);
        rd(0, 0, "restart_w0_kept"); rd(0, 1, "restart_w1_kept");
        ldw = '{16'h0123, 16'h8000, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        load(0, 1, 1, "reload0");
        rd(1, 5, "concurrent_st"); rd(0, 1, "reload_w1");

        tick(); rel = 2'b10; ld_start = 1; ld_ch = 1; st_we = 1; st_ch = 1; st_sel = 0; st_data = 16'h9999;
        tick(); rel = 2'b00; ld_start = 0; st_we = 0;
        mw[1][0] = 16'hFFFF;
        sb_push(K_ERR, 0, 16'd0, "relovr_err", 0);
        flags(1, 0, 0, 0, "relovr");
        rd(1, 0, "relovr_w0"); rd(1, 4, "relovr_w4"); rd(1, 1, "relovr_w1");
        rd(3, 0, "rd_ch_oob"); rd(0, 6, "rd_addr6"); rd(0, 7, "rd_addr7");

        tick(); rd_ch = 0; rd_addr = 3'd4; st_we = 1; st_ch = 0; st_sel = 0; st_data = 16'h0BEE;
        sb_push(K_RD, 0, mw[0][4], "rbw_old", RDLAT);
        mw[0][4] = 16'h0BEE;
        tick(); st_we = 0;
        rd(0, 4, "rbw_new");
        rd(0, 0, "b2b_w0"); rd(0, 1, "b2b_w1"); rd(0, 2, "b2b_w2");

        tick(); rel = 2'b01;
        tick(); rel = 2'b00; ld_start = 1; ld_ch = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); ld_start = 0; ld_we = 1; ld_data = 16'(i + 1);
        end
        tick(); ld_we = 0;
        sb_push(K_BSY, 0, 16'd1, "prerst_busy", 0);
        repeat (3) tick();
        @(negedge clk);
        clk_en = 0;
        rd_ch = 0; rd_addr = 3'd1;
        #2 rst_n = 0;
        #2;
        chk("arst_busy", busy, 2'b00);
        chk("arst_vld", desc_vld, 2'b00);
        chk("arst_chain", desc_chain, 2'b00);
        chk("arst_err", ld_err, 1'b0);
        chk("arst_rd_w1", rd_data, 16'h0000);
        rd_addr = 3'd0;
        #1 chk("arst_rd_w0", rd_data, (RDLAT != 0) ? 16'h0000 : 16'hFFFF);
        #2 rst_n = 1;
        model_reset();
        #2 clk_en = 1;

        ldw = '{16'h0000, 16'hC000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        load(0, 0, 0, "postrst");
        rd(0, 1, "postrst_w1"); rd(0, 5, "postrst_w5"); rd(1, 0, "postrst_c1w0"); rd(1, 1, "postrst_c1w1");

        repeat (4) tick();
        chk("sb_drained", sb_due.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
